simon_core_param: RTL and testbench



---
 rtl/simon_pkg.sv | 46 ++++
 rtl/simon_key_step.sv | 36 +++
 rtl/simon_core_param.sv | 158 +++++++++++++++
 tb/tb_simon_core_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// SIMON shared definitions: z sequences, per-variant round counts, FSM states.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package simon_pkg;

    // Written so that the leftmost character is z[0]; read bit j as Z[61-j].
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        RUN    = 2'd2
    } state_t;

    function automatic bit legal_pair(input int n, input int m);
        return (n == 16 && m == 4) ||
               (n == 24 && (m == 3 || m == 4)) ||
               (n == 32 && (m == 3 || m == 4));
    endfunction

    function automatic int rounds(input int n, input int m);
        if (n == 16) return 32;
        if (n == 24) return 36;
        if (m == 3)  return 42;
        return 44;
    endfunction

    function automatic int zsel(input int n, input int m);
        if (n == 16) return 0;
        if (n == 24) return (m == 3) ? 0 : 1;
        return (m == 3) ? 2 : 3;
    endfunction

    function automatic logic [61:0] zseq(input int idx);
        case (idx)
            0:       return Z0;
            1:       return Z1;
            2:       return Z2;
            default: return Z3;
        endcase
    endfunction

endpackage

// File: rtl/simon_key_step.sv
// SIMON key schedule step, forward (next word above window) or backward (word below window).
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: window = key words, word 0 in the LSBs; z_bit = z[j]; backward selects direction;
//        new_word = k[j+m] (forward, window k[j..j+m-1]) or k[j] (backward, window k[j+1..j+m]).
module simon_key_step
    import simon_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4
) (
    input  logic [WORD_W*KEY_WORDS-1:0] window,
    input  logic                        z_bit,
    input  logic                        backward,
    output logic [WORD_W-1:0]           new_word
);

    localparam int W = WORD_W;
    // c = 2^n - 4
    localparam logic [W-1:0] C = {{(W-2){1'b1}}, 2'b00};

    logic [W-1:0] top_w, mid_w, base_w, t_rot, t_mix, t_fin;

    // The same equation serves both directions; only which window slots play
    // k[j+m-1], k[j+1] and k[j] / k[j+m] moves by one position.
    always_comb begin
        top_w  = backward ? window[(KEY_WORDS-2)*W +: W] : window[(KEY_WORDS-1)*W +: W];
        mid_w  = backward ? window[0 +: W]               : window[W +: W];
        base_w = backward ? window[(KEY_WORDS-1)*W +: W] : window[0 +: W];
        t_rot  = {top_w[2:0], top_w[W-1:3]};
        t_mix  = (KEY_WORDS == 4) ? (t_rot ^ mid_w) : t_rot;
        t_fin  = t_mix ^ {t_mix[0], t_mix[W-1:1]};
        new_word = C ^ {{(W-1){1'b0}}, z_bit} ^ base_w ^ t_fin;
    end

endmodule

// File: rtl/simon_core_param.sv
// Iterative SIMON encrypt/decrypt engine, one round per clock, keys generated on the fly.
// Latency: start edge to done: T+1 cycles encrypt, 2T+1 decrypt (T forward key steps first).
// Backpressure: start is ignored while busy; no output stall, done is a single-cycle pulse.
// Ports: clk, rst_n (async active-low); start/decrypt sampled in IDLE; key_in {k[m-1]..k[0]};
//        block_in/block_out {x, y}; busy between accept and done (exclusive); done pulse.
module simon_core_param
    import simon_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        decrypt,
    input  logic [WORD_W*KEY_WORDS-1:0] key_in,
    input  logic [2*WORD_W-1:0]         block_in,
    output logic [2*WORD_W-1:0]         block_out,
    output logic                        busy,
    output logic                        done
);

    localparam int            W        = WORD_W;
    localparam int            KW       = WORD_W * KEY_WORDS;
    localparam int            T        = rounds(WORD_W, KEY_WORDS);
    localparam logic [5:0]    LAST_RND = 6'(T - 1);
    localparam logic [61:0]   ZS       = zseq(zsel(WORD_W, KEY_WORDS));

    generate
        if (!legal_pair(WORD_W, KEY_WORDS)) begin : g_illegal
            $error("simon_core_param: unsupported WORD_W/KEY_WORDS pair");
        end
    endgenerate

    state_t        state, state_nxt;
    logic [KW-1:0] window;
    logic [W-1:0]  x_q, y_q, x_nxt, y_nxt;
    logic [W-1:0]  key_word, round_key;
    logic          mode_q;
    logic [5:0]    rnd_q, zidx_q, z_inc, z_dec, z_pos;
    logic          z_bit, last_rnd;
    logic          accept, do_expand, do_run, finish, key_backward;

    function automatic logic [W-1:0] f_round(input logic [W-1:0] v);
        return ({v[W-2:0], v[W-1]} & {v[W-9:0], v[W-1:W-8]}) ^ {v[W-3:0], v[W-1:W-2]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = decrypt ? EXPAND : RUN;
            EXPAND:  if (last_rnd) state_nxt = RUN;
            RUN:     if (last_rnd) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept       = 1'b0;
        do_expand    = 1'b0;
        do_run       = 1'b0;
        finish       = 1'b0;
        key_backward = 1'b0;
        case (state)
            IDLE:   accept = start;
            EXPAND: do_expand = 1'b1;
            RUN: begin
                do_run       = 1'b1;
                key_backward = mode_q;
                finish       = last_rnd;
            end
            default: ;
        endcase
    end

    assign last_rnd = (rnd_q == LAST_RND);

    // z index runs mod 62 independently of the round counter; decrypt walks
    // it back down from T, so the backward step uses the pre-decremented value.
    assign z_inc = (zidx_q == 6'd61) ? 6'd0  : zidx_q + 6'd1;
    assign z_dec = (zidx_q == 6'd0)  ? 6'd61 : zidx_q - 6'd1;
    assign z_pos = key_backward ? z_dec : zidx_q;
    assign z_bit = ZS[6'd61 - z_pos];

    simon_key_step #(
        .WORD_W   (WORD_W),
        .KEY_WORDS(KEY_WORDS)
    ) u_key_step (
        .window  (window),
        .z_bit   (z_bit),
        .backward(key_backward),
        .new_word(key_word)
    );

    // Encrypt uses k[i] already at the bottom of the window; decrypt uses the
    // word the backward step produces this cycle.
    assign round_key = mode_q ? key_word : window[W-1:0];

    always_comb begin
        if (mode_q) begin
            x_nxt = y_q;
            y_nxt = x_q ^ f_round(y_q) ^ round_key;
        end else begin
            x_nxt = y_q ^ f_round(x_q) ^ round_key;
            y_nxt = x_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            mode_q    <= 1'b0;
            rnd_q     <= '0;
            zidx_q    <= '0;
            block_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                window <= key_in;
                x_q    <= block_in[2*W-1:W];
                y_q    <= block_in[W-1:0];
                mode_q <= decrypt;
                rnd_q  <= '0;
                zidx_q <= '0;
                busy   <= 1'b1;
            end else if (do_expand) begin
                window <= {key_word, window[KW-1:W]};
                zidx_q <= z_inc;
                rnd_q  <= last_rnd ? 6'd0 : rnd_q + 6'd1;
            end else if (do_run) begin
                x_q   <= x_nxt;
                y_q   <= y_nxt;
                rnd_q <= last_rnd ? 6'd0 : rnd_q + 6'd1;
                if (mode_q) begin
                    window <= {window[KW-W-1:0], key_word};
                    zidx_q <= z_dec;
                end else begin
                    window <= {key_word, window[KW-1:W]};
                    zidx_q <= z_inc;
                end
                if (last_rnd) begin
                    block_out <= {x_nxt, y_nxt};
                    busy      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_simon_core_param.sv
// Directed bench for simon_core_param: three variants (32/64, 48/72, 64/128) on one clock.
// Latency: counted in cycles from the start cycle to the cycle done is seen high.
// Backpressure: exercises ignored starts while busy and a start in the done cycle.
module tb_simon_core_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start_a, dec_a, busy_a, done_a;
    logic [63:0]  key_a;
    logic [31:0]  blk_a, out_a;
    logic         start_b, dec_b, busy_b, done_b;
    logic [71:0]  key_b;
    logic [47:0]  blk_b, out_b;
    logic         start_c, dec_c, busy_c, done_c;
    logic [127:0] key_c;
    logic [63:0]  blk_c, out_c;

    simon_core_param #(.WORD_W(16), .KEY_WORDS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .decrypt(dec_a), .key_in(key_a),
        .block_in(blk_a), .block_out(out_a), .busy(busy_a), .done(done_a));
    simon_core_param #(.WORD_W(24), .KEY_WORDS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .decrypt(dec_b), .key_in(key_b),
        .block_in(blk_b), .block_out(out_b), .busy(busy_b), .done(done_b));
    simon_core_param #(.WORD_W(32), .KEY_WORDS(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .decrypt(dec_c), .key_in(key_c),
        .block_in(blk_c), .block_out(out_c), .busy(busy_c), .done(done_c));

    localparam logic [127:0] K64  = 128'h1918_1110_0908_0100;
    localparam logic [127:0] K72  = 128'h121110_0a0908_020100;
    localparam logic [127:0] K128 = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  PT32 = 64'h6565_6877;
    localparam logic [63:0]  CT32 = 64'hc69b_e9bb;
    localparam logic [63:0]  PT48 = 64'h612067_6e696c;
    localparam logic [63:0]  CT48 = 64'hdae5ac_292cac;
    localparam logic [63:0]  PT64 = 64'h656b696c_20646e75;
    localparam logic [63:0]  CT64 = 64'h44c8fc20_b9dfa07a;

    int n_checks = 0;
    int n_errors = 0;

    int          cur = 0;
    logic        m_done, m_busy;
    logic [63:0] m_out;

    always_comb begin
        m_done = done_a;
        m_busy = busy_a;
        m_out  = {32'b0, out_a};
        case (cur)
            1: begin m_done = done_b; m_busy = busy_b; m_out = {16'b0, out_b}; end
            2: begin m_done = done_c; m_busy = busy_c; m_out = out_c; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [127:0] key,
                         input logic [63:0] blk, input logic dec);
        case (sel)
            1: begin start_b = st; key_b = key[71:0]; blk_b = blk[47:0]; dec_b = dec; end
            2: begin start_c = st; key_c = key;       blk_c = blk;       dec_c = dec; end
            default: begin start_a = st; key_a = key[63:0]; blk_a = blk[31:0]; dec_a = dec; end
        endcase
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or on timeout).
    // Pokes pulse start with inverted key/block/mode while the op is running.
    task automatic run_op(input int sel, input logic [127:0] key, input logic [63:0] blk,
                          input logic dec, input int poke_a, input int poke_b,
                          output logic [63:0] res, output int cyc, output bit busy_ok);
        bit junk;
        junk    = 1'b0;
        cur     = sel;
        busy_ok = 1'b1;
        drive(sel, 1'b1, key, blk, dec);
        cyc = 0;
        @(negedge clk);
        cyc = 1;
        drive(sel, 1'b0, key, blk, dec);
        while (!m_done && cyc < 400) begin
            if (!m_busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
            if (cyc == poke_a || cyc == poke_b) begin
                junk = 1'b1;
                drive(sel, 1'b1, ~key, ~blk, ~dec);
            end else if (junk) begin
                drive(sel, 1'b0, ~key, ~blk, ~dec);
            end
        end
        if (m_busy) busy_ok = 1'b0;
        drive(sel, 1'b0, key, blk, dec);
        res = m_out;
    endtask

    logic [63:0] res;
    int          cyc;
    bit          bok;
    int          stray;

    initial begin
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        drive(2, 1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst out_a", {32'b0, out_a}, 64'd0);
        check("rst busy_a", {63'b0, busy_a}, 64'd0);
        check("rst done_a", {63'b0, done_a}, 64'd0);
        check("rst out_b", {16'b0, out_b}, 64'd0);
        check("rst out_c", out_c, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SIMON32/64
        run_op(0, K64, PT32, 1'b0, 0, 0, res, cyc, bok);
        check("enc32 ct", res, CT32);
        check("enc32 latency", 64'(cyc), 64'd33);
        check("enc32 busy", 64'(bok), 64'd1);
        @(negedge clk);
        check("enc32 done one cycle", {63'b0, done_a}, 64'd0);
        check("enc32 out held", {32'b0, out_a}, CT32);
        run_op(0, K64, CT32, 1'b1, 0, 0, res, cyc, bok);
        check("dec32 pt", res, PT32);
        check("dec32 latency", 64'(cyc), 64'd65);
        check("dec32 busy", 64'(bok), 64'd1);
        @(negedge clk);

        // SIMON48/72
        run_op(1, K72, PT48, 1'b0, 0, 0, res, cyc, bok);
        check("enc48 ct", res, CT48);
        check("enc48 latency", 64'(cyc), 64'd37);
        @(negedge clk);
        run_op(1, K72, CT48, 1'b1, 0, 0, res, cyc, bok);
        check("dec48 pt", res, PT48);
        check("dec48 latency", 64'(cyc), 64'd73);
        @(negedge clk);

        // SIMON64/128
        run_op(2, K128, PT64, 1'b0, 0, 0, res, cyc, bok);
        check("enc64 ct", res, CT64);
        check("enc64 latency", 64'(cyc), 64'd45);
        @(negedge clk);
        run_op(2, K128, CT64, 1'b1, 0, 0, res, cyc, bok);
        check("dec64 pt", res, PT64);
        check("dec64 latency", 64'(cyc), 64'd89);
        @(negedge clk);

        // Starts at cycles 5 and 20 with altered inputs must be ignored;
        // then a start in the done cycle must be accepted.
        run_op(0, K64, PT32, 1'b0, 5, 20, res, cyc, bok);
        check("poke ct", res, CT32);
        check("poke latency", 64'(cyc), 64'd33);
        run_op(0, K64, CT32, 1'b1, 0, 0, res, cyc, bok);
        check("done-cycle start pt", res, PT32);
        check("done-cycle start latency", 64'(cyc), 64'd65);
        @(negedge clk);

        // Abort around round 10 by reset.
        cur = 0;
        drive(0, 1'b1, K64, PT32, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, K64, PT32, 1'b0);
        check("out held after start", {32'b0, out_a}, PT32);
        check("busy after start", {63'b0, busy_a}, 64'd1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", {63'b0, busy_a}, 64'd0);
        check("abort done", {63'b0, done_a}, 64'd0);
        check("abort out", {32'b0, out_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_a || busy_a) stray++;
        end
        check("abort no done", 64'(stray), 64'd0);
        run_op(0, K64, PT32, 1'b0, 0, 0, res, cyc, bok);
        check("post-abort ct", res, CT32);
        check("post-abort latency", 64'(cyc), 64'd33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
